// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared bomb-game types, widths and default time constants
package bomb_pkg;

    localparam int CODE_W = 5;
    localparam int SECS_W = 5;

    localparam int DEF_TICK_DIV    = 50_000_000;
    localparam int DEF_SHOW_SEC    = 5;
    localparam int DEF_COUNT_SEC   = 20;
    localparam int DEF_RESULT_SEC  = 3;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_PENALTY_SEC = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW,
        ST_COUNT,
        ST_FAIL,
        ST_SUCCESS,
        ST_RESTART
    } round_state_t;

    // Countdown subtraction that stops at zero instead of wrapping.
    function automatic logic [SECS_W-1:0] sat_sub(input logic [SECS_W-1:0] a,
                                                  input logic [SECS_W:0]   b);
        if (b >= {1'b0, a})
            return '0;
        else
            return a - b[SECS_W-1:0];
    endfunction

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - one-second tick divider; clr restarts the second on the same cycle
module sec_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_p,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_eff;

    // clr makes the current cycle count as zero, so a new state always gets a full second.
    assign cnt_eff = clr ? '0 : cnt;
    assign tick    = (cnt_eff == LAST);

    always_ff @(posedge clk) begin
        if (rst_p)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt_eff + W'(1);
    end

endmodule

// File: rtl/defuse_round_fsm.sv
// rtl/defuse_round_fsm.sv - one defusal round (show, countdown, guesses, result); option LOCKOUT_PENALTY_EN
module defuse_round_fsm
    import bomb_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int SHOW_SEC    = DEF_SHOW_SEC,
    parameter int COUNT_SEC   = DEF_COUNT_SEC,
    parameter int RESULT_SEC  = DEF_RESULT_SEC,
    parameter int MAX_TRIES   = DEF_MAX_TRIES,
    parameter int PENALTY_SEC = DEF_PENALTY_SEC
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              showing,
    input  logic [CODE_W-1:0] random,
    input  logic              start,
    input  logic              startInput,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              endOfShow,
    output logic              infail,
    output logic              insuccess,
    output logic              repeatRst,
    output logic [SECS_W-1:0] secs_left,
    output logic [1:0]        tries_left
);

    typedef logic [SECS_W:0] amt_t;

    localparam logic [7:0]        SHOW_LAST   = 8'(SHOW_SEC - 1);
    localparam logic [7:0]        RESULT_LAST = 8'(RESULT_SEC - 1);
    localparam logic [SECS_W-1:0] COUNT_INIT  = SECS_W'(COUNT_SEC);
    localparam logic [1:0]        TRIES_INIT  = 2'(MAX_TRIES);
    localparam amt_t              PEN_AMT     = amt_t'(PENALTY_SEC);
`ifdef LOCKOUT_PENALTY_EN
    localparam bit                PEN_EN      = 1'b1;
`else
    localparam bit                PEN_EN      = 1'b0;
`endif

    round_state_t      state;
    round_state_t      state_d1;
    logic [CODE_W-1:0] code;
    logic [7:0]        sec_cnt;
    logic              tick;
    logic              entered;

    assign entered = (state != state_d1);

    sec_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick (
        .clk   (clk),
        .rst_p (rst_p),
        .clr   (entered),
        .tick  (tick)
    );

    logic              hit;
    logic              miss;
    amt_t              dec_amt;
    logic [SECS_W-1:0] secs_next;
    logic [1:0]        tries_next;

    always_comb begin
        hit        = code_valid && startInput && (code_in == code);
        miss       = code_valid && startInput && (code_in != code);
        dec_amt    = amt_t'(tick && start) + ((miss && PEN_EN) ? PEN_AMT : amt_t'(0));
        secs_next  = sat_sub(secs_left, dec_amt);
        tries_next = miss ? (tries_left - 2'd1) : tries_left;
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state      <= ST_IDLE;
            state_d1   <= ST_IDLE;
            code       <= '0;
            sec_cnt    <= '0;
            endOfShow  <= 1'b0;
            infail     <= 1'b0;
            insuccess  <= 1'b0;
            repeatRst  <= 1'b0;
            secs_left  <= '0;
            tries_left <= '0;
        end else begin
            state_d1  <= state;
            repeatRst <= 1'b0;
            if (state != ST_IDLE && !showing) begin
                state      <= ST_IDLE;
                sec_cnt    <= '0;
                endOfShow  <= 1'b0;
                infail     <= 1'b0;
                insuccess  <= 1'b0;
                secs_left  <= '0;
                tries_left <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (showing) begin
                            state      <= ST_SHOW;
                            code       <= random;
                            tries_left <= TRIES_INIT;
                            secs_left  <= COUNT_INIT;
                            sec_cnt    <= '0;
                        end
                    end
                    ST_SHOW: begin
                        if (tick) begin
                            if (sec_cnt == SHOW_LAST) begin
                                state     <= ST_COUNT;
                                endOfShow <= 1'b1;
                                sec_cnt   <= '0;
                            end else begin
                                sec_cnt <= sec_cnt + 8'd1;
                            end
                        end
                    end
                    ST_COUNT: begin
                        // A correct guess beats a simultaneous final tick; secs_left freezes as-is.
                        if (hit) begin
                            state     <= ST_SUCCESS;
                            insuccess <= 1'b1;
                            sec_cnt   <= '0;
                        end else begin
                            secs_left  <= secs_next;
                            tries_left <= tries_next;
                            if (secs_next == '0 || (miss && tries_next == 2'd0)) begin
                                state   <= ST_FAIL;
                                infail  <= 1'b1;
                                sec_cnt <= '0;
                            end
                        end
                    end
                    ST_FAIL, ST_SUCCESS: begin
                        if (tick) begin
                            if (sec_cnt == RESULT_LAST) begin
                                state     <= ST_RESTART;
                                repeatRst <= 1'b1;
                                endOfShow <= 1'b0;
                                infail    <= 1'b0;
                                insuccess <= 1'b0;
                                sec_cnt   <= '0;
                            end else begin
                                sec_cnt <= sec_cnt + 8'd1;
                            end
                        end
                    end
                    ST_RESTART: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
